// File: rtl/alu_exec_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit_if
// Purpose  : Bundle of execute-stage signals between the operand muxes and
//            control logic on one side and alu_exec_unit on the other.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic [31:0]      inst;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [3:0]       alu_ctrl;
  logic             shift;
  logic             reg_to_pc;
  logic             reg_pc_wr;
  logic [WIDTH-1:0] alu_result;
  logic [7:0]       flags;
  logic [7:0]       flags_q;
  logic             branch;
  logic             jump;
  logic [3:0]       cond;
  logic             branch_sel;
  logic             jump_sel;

  // Datapath/control side: supplies instruction and operands.
  modport master (
    output inst, alu_op, op_a, op_b,
    input  alu_ctrl, shift, reg_to_pc, reg_pc_wr, alu_result, flags,
           flags_q, branch, jump, cond, branch_sel, jump_sel
  );

  // Execute unit side.
  modport slave (
    input  inst, alu_op, op_a, op_b,
    output alu_ctrl, shift, reg_to_pc, reg_pc_wr, alu_result, flags,
           flags_q, branch, jump, cond, branch_sel, jump_sel
  );
endinterface
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Purpose  : Execute stage: R-type funct decode, 32-bit ALU with flags,
//            branch/jump decode with condition evaluation, flag register.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  wire logic        CLK,
  input  wire logic        rst_n,
  alu_exec_unit_if.slave   bus
);

  localparam logic [3:0] C_ALU_AND  = 4'b0000;
  localparam logic [3:0] C_ALU_ADD  = 4'b0001;
  localparam logic [3:0] C_ALU_SUB  = 4'b0010;
  localparam logic [3:0] C_ALU_OR   = 4'b0011;
  localparam logic [3:0] C_ALU_XOR  = 4'b0100;
  localparam logic [3:0] C_ALU_NOR  = 4'b0101;
  localparam logic [3:0] C_ALU_SLT  = 4'b0110;
  localparam logic [3:0] C_ALU_SLTU = 4'b0111;
  localparam logic [3:0] C_ALU_SLL  = 4'b1000;
  localparam logic [3:0] C_ALU_SRL  = 4'b1001;
  localparam logic [3:0] C_ALU_SRA  = 4'b1010;
  localparam logic [3:0] C_ALU_LUI  = 4'b1011;
  localparam logic [3:0] C_OP_RTYPE = 4'b1111;

  localparam logic [3:0] C_COND_NONE = 4'b0000;
  localparam logic [3:0] C_COND_EQ   = 4'b0001;
  localparam logic [3:0] C_COND_NE   = 4'b0010;
  localparam logic [3:0] C_COND_LEZ  = 4'b0011;
  localparam logic [3:0] C_COND_GTZ  = 4'b0100;

  logic [3:0]       w_alu_ctrl;
  logic             w_shift;
  logic             w_reg_to_pc;
  logic             w_reg_pc_wr;
  logic [WIDTH-1:0] w_result;
  logic             w_c;
  logic             w_v;
  logic [7:0]       w_flags;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [4:0]       w_shamt;
  logic             w_branch;
  logic             w_jump;
  logic [3:0]       w_cond;
  logic             w_cond_true;
  logic [7:0]       r_flags_q;

  // Function decode: pass alu_op through, or decode funct for R-type.
  always_comb begin
    w_alu_ctrl  = bus.alu_op;
    w_shift     = 1'b0;
    w_reg_to_pc = 1'b0;
    w_reg_pc_wr = 1'b0;
    if (bus.alu_op == C_OP_RTYPE) begin
      w_alu_ctrl = C_ALU_ADD;
      case (bus.inst[5:0])
        6'b100000, 6'b100001: w_alu_ctrl = C_ALU_ADD;
        6'b100010, 6'b100011: w_alu_ctrl = C_ALU_SUB;
        6'b100100: w_alu_ctrl = C_ALU_AND;
        6'b100101: w_alu_ctrl = C_ALU_OR;
        6'b100110: w_alu_ctrl = C_ALU_XOR;
        6'b100111: w_alu_ctrl = C_ALU_NOR;
        6'b101010: w_alu_ctrl = C_ALU_SLT;
        6'b101011: w_alu_ctrl = C_ALU_SLTU;
        6'b000000: begin w_alu_ctrl = C_ALU_SLL; w_shift = 1'b1; end
        6'b000010: begin w_alu_ctrl = C_ALU_SRL; w_shift = 1'b1; end
        6'b000011: begin w_alu_ctrl = C_ALU_SRA; w_shift = 1'b1; end
        6'b000100: w_alu_ctrl = C_ALU_SLL;
        6'b000110: w_alu_ctrl = C_ALU_SRL;
        6'b000111: w_alu_ctrl = C_ALU_SRA;
        6'b001000: w_reg_to_pc = 1'b1;
        6'b001001: begin w_reg_to_pc = 1'b1; w_reg_pc_wr = 1'b1; end
        default:   w_alu_ctrl = C_ALU_ADD;
      endcase
    end
  end

  // Extra top bit carries the adder carry-out / subtractor borrow.
  assign w_sum   = {1'b0, bus.op_a} + {1'b0, bus.op_b};
  assign w_diff  = {1'b0, bus.op_a} - {1'b0, bus.op_b};
  assign w_shamt = bus.op_a[4:0];

  // ALU result plus carry and overflow; C is "no borrow" for compares.
  always_comb begin
    w_result = '0;
    w_c      = 1'b0;
    w_v      = 1'b0;
    case (w_alu_ctrl)
      C_ALU_AND: w_result = bus.op_a & bus.op_b;
      C_ALU_ADD: begin
        w_result = w_sum[WIDTH-1:0];
        w_c      = w_sum[WIDTH];
        w_v      = (bus.op_a[WIDTH-1] == bus.op_b[WIDTH-1]) &&
                   (w_sum[WIDTH-1] != bus.op_a[WIDTH-1]);
      end
      C_ALU_SUB: begin
        w_result = w_diff[WIDTH-1:0];
        w_c      = ~w_diff[WIDTH];
        w_v      = (bus.op_a[WIDTH-1] != bus.op_b[WIDTH-1]) &&
                   (w_diff[WIDTH-1] != bus.op_a[WIDTH-1]);
      end
      C_ALU_OR:  w_result = bus.op_a | bus.op_b;
      C_ALU_XOR: w_result = bus.op_a ^ bus.op_b;
      C_ALU_NOR: w_result = ~(bus.op_a | bus.op_b);
      C_ALU_SLT: begin
        w_result = {{(WIDTH-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
        w_c      = ~w_diff[WIDTH];
      end
      C_ALU_SLTU: begin
        w_result = {{(WIDTH-1){1'b0}}, w_diff[WIDTH]};
        w_c      = ~w_diff[WIDTH];
      end
      C_ALU_SLL: w_result = bus.op_b << w_shamt;
      C_ALU_SRL: w_result = bus.op_b >> w_shamt;
      C_ALU_SRA: w_result = $signed(bus.op_b) >>> w_shamt;
      C_ALU_LUI: w_result = bus.op_b << 16;
      default:   w_result = '0;
    endcase
  end

  assign w_flags = {4'b0000, w_v, w_c, w_result[WIDTH-1], (w_result == '0)};

  // Branch/jump classification from the primary opcode.
  always_comb begin
    w_branch = 1'b0;
    w_jump   = 1'b0;
    w_cond   = C_COND_NONE;
    case (bus.inst[31:26])
      6'b000010, 6'b000011: w_jump = 1'b1;
      6'b000100: begin w_branch = 1'b1; w_cond = C_COND_EQ;  end
      6'b000101: begin w_branch = 1'b1; w_cond = C_COND_NE;  end
      6'b000110: begin w_branch = 1'b1; w_cond = C_COND_LEZ; end
      6'b000111: begin w_branch = 1'b1; w_cond = C_COND_GTZ; end
      default: ;
    endcase
  end

  // Condition evaluation on the live flags of the compare-by-subtract.
  always_comb begin
    w_cond_true = 1'b0;
    case (w_cond)
      C_COND_EQ:  w_cond_true = w_flags[0];
      C_COND_NE:  w_cond_true = ~w_flags[0];
      C_COND_LEZ: w_cond_true = w_flags[0] | (w_flags[1] ^ w_flags[3]);
      C_COND_GTZ: w_cond_true = ~w_flags[0] & ~(w_flags[1] ^ w_flags[3]);
      default:    w_cond_true = 1'b0;
    endcase
  end

  // Status register: snapshot of the live flags every cycle.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) r_flags_q <= '0;
    else        r_flags_q <= w_flags;
  end

  assign bus.alu_ctrl   = w_alu_ctrl;
  assign bus.shift      = w_shift;
  assign bus.reg_to_pc  = w_reg_to_pc;
  assign bus.reg_pc_wr  = w_reg_pc_wr;
  assign bus.alu_result = w_result;
  assign bus.flags      = w_flags;
  assign bus.flags_q    = r_flags_q;
  assign bus.branch     = w_branch;
  assign bus.jump       = w_jump;
  assign bus.cond       = w_cond;
  assign bus.branch_sel = w_branch & w_cond_true;
  assign bus.jump_sel   = w_jump;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_unit
// Purpose  : Directed self-checking bench for alu_exec_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

  logic CLK;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  alu_exec_unit_if #(.WIDTH(32)) bus ();

  alu_exec_unit #(.WIDTH(32)) dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Apply a vector just after a falling edge and let it settle.
  task automatic apply(input logic [31:0] inst, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    bus.inst   = inst;
    bus.alu_op = op;
    bus.op_a   = a;
    bus.op_b   = b;
    #1;
  endtask

  initial begin
    n_checks   = 0;
    n_fails    = 0;
    rst_n      = 1'b0;
    bus.inst   = 32'h0;
    bus.alu_op = 4'b0001;
    bus.op_a   = 32'h0;
    bus.op_b   = 32'h0;
    #12;
    chk("reset_flags_q", {24'h0, bus.flags_q}, 32'h0);

    // ADD wrap: FFFFFFFF + 1 = 0, Z=1 C=1
    apply(32'h0, 4'b0001, 32'hFFFF_FFFF, 32'h1);
    chk("add_result", bus.alu_result, 32'h0);
    chk("add_flags", {24'h0, bus.flags}, 32'h05);
    chk("rst_comb_ctrl", {28'h0, bus.alu_ctrl}, 32'h1);
    rst_n = 1'b1;

    // AND 1&1 = 1 -> all flags 0, latched on next edge
    apply(32'h0, 4'b0000, 32'h1, 32'h1);
    chk("and_result", bus.alu_result, 32'h1);
    chk("and_flags", {24'h0, bus.flags}, 32'h00);

    // SUB 80000000-1 = 7FFFFFFF, V=1 C=1 N=0 Z=0
    apply(32'h0, 4'b0010, 32'h8000_0000, 32'h1);
    chk("sub_result", bus.alu_result, 32'h7FFF_FFFF);
    chk("sub_flags", {24'h0, bus.flags}, 32'h0C);
    chk("flags_q_before", {24'h0, bus.flags_q}, 32'h00);
    @(posedge CLK); #1;
    chk("flags_q_after", {24'h0, bus.flags_q}, 32'h0C);

    // R-type SRA immediate: 80000000 >>> 4
    apply(32'h0000_0003, 4'b1111, 32'h4, 32'h8000_0000);
    chk("sra_shift", {31'h0, bus.shift}, 32'h1);
    chk("sra_ctrl", {28'h0, bus.alu_ctrl}, 32'hA);
    chk("sra_result", bus.alu_result, 32'hF800_0000);

    // jalr
    apply(32'h0000_0009, 4'b1111, 32'h4, 32'h8000_0000);
    chk("jalr_ctrls", {29'h0, bus.reg_to_pc, bus.reg_pc_wr, bus.shift}, 32'h6);
    chk("jalr_ctrl", {28'h0, bus.alu_ctrl}, 32'h1);

    // Unknown funct defaults to ADD with controls cleared
    apply(32'h0000_003F, 4'b1111, 32'h2, 32'h3);
    chk("unk_funct", {25'h0, bus.alu_ctrl, bus.shift, bus.reg_to_pc, bus.reg_pc_wr}, 32'h08);
    chk("unk_result", bus.alu_result, 32'h5);

    // SLT -1 < 1 signed; unsigned A>=B so C=1
    apply(32'h0, 4'b0110, 32'hFFFF_FFFF, 32'h1);
    chk("slt_result", bus.alu_result, 32'h1);
    chk("slt_flags", {24'h0, bus.flags}, 32'h04);

    // SLTU FFFFFFFF < 1 unsigned is false
    apply(32'h0, 4'b0111, 32'hFFFF_FFFF, 32'h1);
    chk("sltu_result", bus.alu_result, 32'h0);

    // LUI and an unused ALU code
    apply(32'h0, 4'b1011, 32'h0, 32'h0000_1234);
    chk("lui_result", bus.alu_result, 32'h1234_0000);
    apply(32'h0, 4'b1100, 32'h7, 32'h9);
    chk("bad_op_result", bus.alu_result, 32'h0);
    chk("bad_op_flags", {24'h0, bus.flags}, 32'h01);

    // BEQ taken / not taken
    apply({6'b000100, 26'h0}, 4'b0010, 32'h5, 32'h5);
    chk("beq_decode", {27'h0, bus.branch, bus.cond}, 32'h11);
    chk("beq_taken", {31'h0, bus.branch_sel}, 32'h1);
    apply({6'b000100, 26'h0}, 4'b0010, 32'h5, 32'h6);
    chk("beq_not_taken", {31'h0, bus.branch_sel}, 32'h0);

    // BNE on unequal operands
    apply({6'b000101, 26'h0}, 4'b0010, 32'h5, 32'h6);
    chk("bne_taken", {27'h0, bus.branch_sel, bus.cond}, 32'h12);

    // BGTZ negative / positive
    apply({6'b000111, 26'h0}, 4'b0010, 32'hFFFF_FFFF, 32'h0);
    chk("bgtz_neg", {31'h0, bus.branch_sel}, 32'h0);
    apply({6'b000111, 26'h0}, 4'b0010, 32'h3, 32'h0);
    chk("bgtz_pos", {27'h0, bus.branch_sel, bus.cond}, 32'h14);

    // BLEZ on zero
    apply({6'b000110, 26'h0}, 4'b0010, 32'h0, 32'h0);
    chk("blez_zero", {27'h0, bus.branch_sel, bus.cond}, 32'h13);

    // Jump
    apply({6'b000010, 26'h0}, 4'b0010, 32'h5, 32'h5);
    chk("j_sel", {29'h0, bus.jump, bus.jump_sel, bus.branch_sel}, 32'h6);
    chk("j_cond", {28'h0, bus.cond}, 32'h0);

    // Mid-cycle asynchronous reset
    apply(32'h0, 4'b0001, 32'hFFFF_FFFF, 32'h1);
    @(posedge CLK); #1;
    chk("pre_rst_flags_q", {24'h0, bus.flags_q}, 32'h05);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_flags_q", {24'h0, bus.flags_q}, 32'h00);
    chk("rst_comb_result", bus.alu_result, 32'h0);
    @(negedge CLK);
    rst_n = 1'b1;
    #1;
    chk("post_rst_hold", {24'h0, bus.flags_q}, 32'h00);
    @(posedge CLK); #1;
    chk("post_rst_update", {24'h0, bus.flags_q}, 32'h05);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
